// File: rtl/arb3_pkg.sv
// Shared types and constants for the three-way priority arbiter.
package arb3_pkg;
   localparam int NUM_REQ = 3;
   localparam int PRIO_W  = 3;
   localparam int ID_W    = 2;

   typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

   // Modulo-3 increment of a requester index (values 0..2 only).
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == 2'd2) ? 2'd0 : id + 2'd1;
   endfunction
endpackage

// File: rtl/max_prio_pick.sv
// Picks the highest-priority candidate; ties go to the first candidate in rotation order from rr_ptr.
// Purely combinational, no flow control.
module max_prio_pick
   import arb3_pkg::*;
(
   input  logic [NUM_REQ-1:0] cand,
   input  logic [PRIO_W-1:0]  prio0,
   input  logic [PRIO_W-1:0]  prio1,
   input  logic [PRIO_W-1:0]  prio2,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               valid,
   output logic [ID_W-1:0]    win
);
   logic [PRIO_W-1:0] prio  [NUM_REQ];
   logic [ID_W-1:0]   order [NUM_REQ];
   logic [PRIO_W-1:0] best;

   assign prio[0]  = prio0;
   assign prio[1]  = prio1;
   assign prio[2]  = prio2;
   assign order[0] = rr_ptr;
   assign order[1] = next_id(rr_ptr);
   assign order[2] = next_id(order[1]);

   // Strict greater-than keeps the earliest candidate in rotation order on a tie.
   always_comb begin
      valid = 1'b0;
      win   = '0;
      best  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (cand[order[k]] && (!valid || prio[order[k]] > best)) begin
            valid = 1'b1;
            win   = order[k];
            best  = prio[order[k]];
         end
      end
   end
endmodule

// File: rtl/prio_arbiter3.sv
// Three-requester priority arbiter with rotating tie-break, hold timeout and post-timeout lockout.
// Grant one cycle after arbitration; owner is never preempted, release or timeout costs one RECOVER cycle.
module prio_arbiter3
   import arb3_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [PRIO_W-1:0]  prio0,
   input  logic [PRIO_W-1:0]  prio1,
   input  logic [PRIO_W-1:0]  prio2,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               busy,
   output logic               timeout
);
   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t             state, state_nxt;
   logic [CW-1:0]      hold_cnt, hold_nxt;
   logic [ID_W-1:0]    rr_ptr, rr_nxt;
   logic [ID_W-1:0]    owner, owner_nxt;
   logic [NUM_REQ-1:0] lockout, lock_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic [ID_W-1:0]    gnt_id_nxt;
   logic               busy_nxt, timeout_nxt;
   logic [NUM_REQ-1:0] cand;
   logic               pick_vld;
   logic [ID_W-1:0]    pick_id;
   logic               release_req, hold_hit;

   // A locked-out requester still wins when it is the only one asking.
   assign cand        = ((req & ~lockout) != '0) ? (req & ~lockout) : req;
   assign release_req = !req[owner];
   assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   max_prio_pick u_pick (
      .cand   (cand),
      .prio0  (prio0),
      .prio1  (prio1),
      .prio2  (prio2),
      .rr_ptr (rr_ptr),
      .valid  (pick_vld),
      .win    (pick_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         rr_ptr   <= '0;
         owner    <= '0;
         lockout  <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rr_ptr   <= rr_nxt;
         owner    <= owner_nxt;
         lockout  <= lock_nxt;
         gnt      <= gnt_nxt;
         gnt_id   <= gnt_id_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = BUSY;
         BUSY:    if (release_req || hold_hit) state_nxt = RECOVER;
         RECOVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt     = '0;
      gnt_id_nxt  = '0;
      busy_nxt    = 1'b0;
      timeout_nxt = 1'b0;
      hold_nxt    = hold_cnt;
      rr_nxt      = rr_ptr;
      owner_nxt   = owner;
      lock_nxt    = lockout;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               gnt_nxt    = NUM_REQ'(1) << pick_id;
               gnt_id_nxt = pick_id;
               busy_nxt   = 1'b1;
               hold_nxt   = '0;
               lock_nxt   = '0;
               owner_nxt  = pick_id;
            end
         end
         BUSY: begin
            hold_nxt = hold_cnt + 1'b1;
            if (release_req) begin
               // Normal release wins over a coincident timeout.
            end else if (hold_hit) begin
               timeout_nxt = 1'b1;
               lock_nxt    = lockout | (NUM_REQ'(1) << owner);
            end else begin
               gnt_nxt    = gnt;
               gnt_id_nxt = gnt_id;
               busy_nxt   = 1'b1;
            end
         end
         RECOVER: rr_nxt = next_id(owner);
         default: ;
      endcase
   end
endmodule

// File: tb/tb_prio_arbiter3.sv
// Cycle-table bench for prio_arbiter3 (MAX_HOLD=4) with a scoreboard queue and a bounded timeout sequence.
module tb_prio_arbiter3;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req, prio0, prio1, prio2;
   logic [2:0] gnt;
   logic [1:0] gnt_id;
   logic       busy, timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prio_arbiter3 #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .prio0   (prio0),
      .prio1   (prio1),
      .prio2   (prio2),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   typedef struct {
      logic       rst;
      logic [2:0] req, p0, p1, p2;
      logic [2:0] gnt;
      logic [1:0] id;
      logic       busy, to;
      int         tag;
   } vec_t;

   typedef struct packed {
      logic [2:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       to;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic void add(input int tag, input int r, input int rq, input int p0, input int p1,
                               input int p2, input int g, input int id, input int b, input int t);
      vec_t v;
      v.rst = 1'(r);  v.req = 3'(rq); v.p0 = 3'(p0); v.p1 = 3'(p1); v.p2 = 3'(p2);
      v.gnt = 3'(g);  v.id = 2'(id);  v.busy = 1'(b); v.to = 1'(t); v.tag = tag;
      tbl.push_back(v);
   endfunction

   task automatic check_bit(input string name, input logic act, input logic req_v);
      n_checks++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %0b, required %0b", name, act, req_v);
      end
   endtask

   initial begin
      exp_t e, a;
      int   gcnt;
      bit   seen_to;

      rst = 1'b1; req = '0; prio0 = '0; prio1 = '0; prio2 = '0;

      // tag, rst, req, p0, p1, p2 -> gnt, id, busy, timeout
      add(0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
      add(0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
      // 1: priority pick, release, 2-cycle gap
      add(1, 0, 3'b011, 2, 5, 0, 3'b010, 1, 1, 0);
      add(1, 0, 3'b011, 2, 5, 0, 3'b010, 1, 1, 0);
      add(1, 0, 3'b001, 2, 5, 0, 3'b000, 0, 0, 0);
      add(1, 0, 3'b001, 2, 5, 0, 3'b000, 0, 0, 0);
      add(1, 0, 3'b001, 2, 5, 0, 3'b001, 0, 1, 0);
      add(1, 0, 3'b000, 2, 5, 0, 3'b000, 0, 0, 0);
      add(1, 0, 3'b000, 2, 5, 0, 3'b000, 0, 0, 0);
      // 2: equal priorities rotate
      add(2, 1, 3'b000, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b001, 0, 1, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b001, 0, 1, 0);
      add(2, 0, 3'b110, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b010, 1, 1, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b010, 1, 1, 0);
      add(2, 0, 3'b101, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b100, 2, 1, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b100, 2, 1, 0);
      add(2, 0, 3'b011, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b111, 4, 4, 4, 3'b001, 0, 1, 0);
      add(2, 0, 3'b000, 4, 4, 4, 3'b000, 0, 0, 0);
      add(2, 0, 3'b000, 4, 4, 4, 3'b000, 0, 0, 0);
      // 3: timeout after 4 cycles, lockout hands over, then back
      for (int i = 0; i < 4; i++) add(3, 0, 3'b101, 7, 0, 1, 3'b001, 0, 1, 0);
      add(3, 0, 3'b101, 7, 0, 1, 3'b000, 0, 0, 1);
      add(3, 0, 3'b101, 7, 0, 1, 3'b000, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(3, 0, 3'b101, 7, 0, 1, 3'b100, 2, 1, 0);
      add(3, 0, 3'b101, 7, 0, 1, 3'b000, 0, 0, 1);
      add(3, 0, 3'b101, 7, 0, 1, 3'b000, 0, 0, 0);
      add(3, 0, 3'b101, 7, 0, 1, 3'b001, 0, 1, 0);
      add(3, 0, 3'b000, 7, 0, 1, 3'b000, 0, 0, 0);
      add(3, 0, 3'b000, 7, 0, 1, 3'b000, 0, 0, 0);
      // 4: release coincides with last hold cycle -> no timeout, no lockout
      for (int i = 0; i < 4; i++) add(4, 0, 3'b101, 7, 0, 1, 3'b001, 0, 1, 0);
      add(4, 0, 3'b100, 7, 0, 1, 3'b000, 0, 0, 0);
      add(4, 0, 3'b101, 7, 0, 1, 3'b000, 0, 0, 0);
      add(4, 0, 3'b101, 7, 0, 1, 3'b001, 0, 1, 0);
      add(4, 0, 3'b000, 7, 0, 1, 3'b000, 0, 0, 0);
      add(4, 0, 3'b000, 7, 0, 1, 3'b000, 0, 0, 0);
      // 5: no preemption by a higher-priority newcomer
      add(5, 0, 3'b001, 1, 0, 7, 3'b001, 0, 1, 0);
      add(5, 0, 3'b101, 1, 0, 7, 3'b001, 0, 1, 0);
      add(5, 0, 3'b101, 1, 0, 7, 3'b001, 0, 1, 0);
      add(5, 0, 3'b100, 1, 0, 7, 3'b000, 0, 0, 0);
      add(5, 0, 3'b100, 1, 0, 7, 3'b000, 0, 0, 0);
      add(5, 0, 3'b100, 1, 0, 7, 3'b100, 2, 1, 0);
      add(5, 0, 3'b100, 1, 0, 7, 3'b100, 2, 1, 0);
      // 6: reset mid-grant, including on the would-be timeout edge
      add(6, 1, 3'b100, 4, 4, 4, 3'b000, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(6, 0, 3'b111, 4, 4, 4, 3'b001, 0, 1, 0);
      add(6, 1, 3'b111, 4, 4, 4, 3'b000, 0, 0, 0);
      add(6, 0, 3'b111, 4, 4, 4, 3'b001, 0, 1, 0);
      add(6, 1, 3'b000, 4, 4, 4, 3'b000, 0, 0, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; req = tbl[i].req;
         prio0 = tbl[i].p0; prio1 = tbl[i].p1; prio2 = tbl[i].p2;
         sb.push_back('{gnt: tbl[i].gnt, id: tbl[i].id, busy: tbl[i].busy, to: tbl[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         a = '{gnt: gnt, id: gnt_id, busy: busy, to: timeout};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL vec%0d(test %0d): gnt/id/busy/to got %b/%0d/%b/%b, required %b/%0d/%b/%b",
                     i, tbl[i].tag, a.gnt, a.id, a.busy, a.to, e.gnt, e.id, e.busy, e.to);
         end
      end

      // Lone requester held: bounded wait for the timeout, then it is regranted despite lockout.
      rst = 1'b0; req = 3'b001; prio0 = 3'd3; prio1 = '0; prio2 = '0;
      gcnt = 0; seen_to = 1'b0;
      for (int c = 0; c < 20 && !seen_to; c++) begin
         @(posedge clk); #1;
         if (gnt == 3'b001) gcnt++;
         if (timeout) seen_to = 1'b1;
      end
      check_bit("lone_timeout_seen", seen_to, 1'b1);
      n_checks++;
      if (gcnt != 4) begin
         n_fail++;
         $display("FAIL lone_grant_len: got %0d cycles, required 4", gcnt);
      end
      @(posedge clk); #1;
      check_bit("lone_timeout_one_cycle", timeout, 1'b0);
      check_bit("lone_recover_gap", gnt[0], 1'b0);
      @(posedge clk); #1;
      check_bit("lone_regrant", gnt[0], 1'b1);
      check_bit("lone_regrant_busy", busy, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
